// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the chunk-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic bit chunk_fits(input int unsigned width, input int unsigned chunk);
        return (chunk != 0) && (width % chunk == 0);
    endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit adder; also reports the carry into its MSB for overflow detection.
module chunk_add #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        sum  = full[CHUNK-1:0];
        cout = full[CHUNK];
        // sum bit = a ^ b ^ carry_in, so the MSB carry-in falls out of the sum bit
        cmsb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

endmodule

// File: rtl/serial_chunk_adder.sv
// Adds two WIDTH-bit operands CHUNK bits per cycle with valid/ready handshakes on both sides.
module serial_chunk_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

    if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_chunk
        $error("serial_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t              state;
    logic [KW-1:0]       k;
    logic                carry;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [CHUNK-1:0]    a_ch;
    logic [CHUNK-1:0]    b_ch;
    logic [CHUNK-1:0]    c_sum;
    logic                c_cout;
    logic                c_msb;
    logic                last;

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (k == KW'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
        last = (k == KW'(NCH - 1));
    end

    chunk_add #(
        .CHUNK(CHUNK)
    ) u_chunk_add (
        .a   (a_ch),
        .b   (b_ch),
        .cin (carry),
        .sum (c_sum),
        .cout(c_cout),
        .cmsb(c_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry    <= cin;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (k == KW'(i)) begin
                            sum[i*CHUNK +: CHUNK] <= c_sum;
                        end
                    end
                    carry <= c_cout;
                    k     <= k + 1'b1;
                    if (last) begin
                        cout      <= c_cout;
                        ovf       <= c_cout ^ c_msb;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench: directed vector table, corner sequences and randomized traffic.
module tb_serial_chunk_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;
    logic        iv8, ir8, cin8, ov8, or8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .ovf(ovf)
    );

    serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8),
        .ovf(ovf8)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
    } op_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-word arithmetic; overflow from operand/result sign rule.
    function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic c);
        logic [16:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + {16'b0, c};
        v = (x[15] == y[15]) && (t[15] != x[15]);
        return {v, t};
    endfunction

    // Called at posedge+1 with the DUT in IDLE; returns after the result is released.
    task automatic run16(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                         input int hold, input logic [15:0] exp_sum,
                         output logic [15:0] gs, output logic gc, output logic go,
                         output int lat);
        int cyc;
        a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = (hold == 0);
        tick();
        cyc = 1;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        end
        lat = cyc;
        gs = sum; gc = cout; go = ovf;
        in_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(exp_sum));
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic run8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                        output logic [7:0] gs, output logic gc, output logic go,
                        output int lat);
        int cyc;
        a8 = xa; b8 = xb; cin8 = xc; iv8 = 1'b1; or8 = 1'b1;
        tick();
        iv8 = 1'b0;
        cyc = 1;
        while (!ov8 && cyc < 20) begin
            tick();
            cyc++;
        end
        lat = cyc;
        gs = sum8; gc = cout8; go = ovf8;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        op_t         q[$];
        op_t         op;
        logic [15:0] gs;
        logic        gc, go;
        logic [7:0]  gs8;
        logic [17:0] r;
        int          lat;
        int          nres;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h000E, 16'h000E, 1'b0, 16'h001C, 1'b0, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        check("rst8_in_ready", 32'(ir8), 32'd1);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run16(vecs[i].a, vecs[i].b, vecs[i].cin, 0, vecs[i].sum, gs, gc, go, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_sum", i), 32'(gs), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(gc), 32'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i), 32'(go), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_in_ready_after", i), 32'(in_ready), 32'd1);
        end

        // Backpressure for 10 cycles with garbage on the operand inputs meanwhile.
        run16(16'h1234, 16'h4321, 1'b1, 10, 16'h5556, gs, gc, go, lat);
        check("bp_latency", 32'(lat), 32'd5);
        check("bp_sum", 32'(gs), 32'h5556);
        check("bp_released", {30'd0, out_valid, in_ready}, 32'd1);

        // Reset in the second RUN cycle discards the operation.
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_result", 32'(out_valid), 32'd0);
        end
        run16(16'h0000, 16'h0001, 1'b1, 0, 16'h0002, gs, gc, go, lat);
        check("postrst_latency", 32'(lat), 32'd5);
        check("postrst_sum", 32'(gs), 32'h0002);
        check("postrst_cout", 32'(gc), 32'd0);

        // Single-chunk configuration.
        run8(8'hFF, 8'hFF, 1'b1, gs8, gc, go, lat);
        check("w8_latency", 32'(lat), 32'd2);
        check("w8_sum", 32'(gs8), 32'hFF);
        check("w8_cout_ovf", {30'd0, gc, go}, 32'd2);
        run8(8'h7F, 8'h01, 1'b0, gs8, gc, go, lat);
        check("w8_ovf_sum", 32'(gs8), 32'h80);
        check("w8_ovf_cout_ovf", {30'd0, gc, go}, 32'd1);

        // Randomized back-to-back traffic, in_valid held high.
        nres = 0;
        for (int i = 0; i < 500; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            in_valid = 1'b1;
            out_ready = ($urandom_range(0, 3) != 0);
            check("rand_excl", {30'd0, in_ready, out_valid} & 32'd3,
                  32'(in_ready ? 2'b10 : (out_valid ? 2'b01 : 2'b00)));
            if (in_ready) q.push_back('{a, b, cin});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_result", 32'd1, 32'd0);
                end else begin
                    op = q.pop_front();
                    r = ref_add(op.a, op.b, op.cin);
                    check("rand_sum", 32'(sum), 32'(r[15:0]));
                    check("rand_cout_ovf", {30'd0, cout, ovf}, {30'd0, r[16], r[17]});
                    nres++;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() != 0; i++) begin
            if (out_valid) begin
                op = q.pop_front();
                r = ref_add(op.a, op.b, op.cin);
                check("drain_sum", 32'(sum), 32'(r[15:0]));
                check("drain_cout_ovf", {30'd0, cout, ovf}, {30'd0, r[16], r[17]});
                nres++;
            end
            tick();
        end
        check("rand_all_results_seen", 32'(q.size()), 32'd0);
        check("rand_some_results", 32'(nres > 50), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: operands valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have ports a and b, input, WIDTH each: addends (unsigned, or two's complement for ovf).
REQ-008 SHALL have port cin, input, 1: carry-in.
REQ-009 SHALL have port out_valid, output, 1: result valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-011 SHALL have port sum, output, WIDTH: a + b + cin modulo 2^WIDTH.
REQ-012 SHALL have port cout, output, 1: carry out of bit WIDTH-1.
REQ-013 SHALL have port ovf, output, 1: signed overflow (carry into MSB XOR cout).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: on in_valid=1, SHALL capture a, b, cin into internal registers, clear chunk index k to 0, and go to RUN.
REQ-017 RUN: each cycle SHALL add chunk k of a and b (bits k*CHUNK+CHUNK-1 .. k*CHUNK) plus the running carry, write that chunk of sum, register the chunk carry-out as the new running carry, and increment k.
REQ-018 RUN SHALL last exactly NCH cycles; after chunk NCH-1 the FSM SHALL go to DONE with cout = final carry and ovf set per REQ-013.
REQ-019 Latency: accept edge at cycle 0; out_valid SHALL rise at cycle NCH+1 (WIDTH=16, CHUNK=4: cycle 5).
REQ-020 DONE: sum, cout and ovf SHALL hold stable while out_ready=0 (indefinite backpressure allowed).
REQ-021 DONE with out_ready=1: SHALL go to IDLE next cycle; in_ready rises that cycle; no same-cycle accept of new operands.
REQ-022 Operand inputs SHALL be ignored outside IDLE; in_valid held high in RUN/DONE SHALL NOT corrupt the result in progress.
REQ-023 sum/cout/ovf SHALL hold their last result in IDLE until the next accept; partial chunks of sum MAY be visible during RUN but SHALL be qualified only by out_valid.
REQ-024 CHUNK = WIDTH SHALL be legal: RUN lasts 1 cycle and out_valid rises at cycle 2.
REQ-025 Wrap-around: a = b = all ones with cin = 1 SHALL give sum all ones and cout = 1.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, k=0, running carry 0, sum=0, cout=0, ovf=0, out_valid=0, and in_ready=1 from the next cycle.
REQ-027 Reset during RUN or DONE SHALL discard the operation with no result output.
REQ-028 rst SHALL take priority over every handshake event in the same cycle.

Structure
REQ-029 Shared package serial_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the elaboration-time check WIDTH % CHUNK == 0.
REQ-030 SHALL instantiate one sub-module chunk_add: combinational CHUNK-bit adder with ports a, b, cin, sum, cout, also exposing the carry into its MSB for ovf.
REQ-031 Target size 120-400 lines of RTL including chunk_add.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-032 a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> out_valid at cycle 5; sum=0x0000, cout=1, ovf=0; in_ready back at cycle 6.
REQ-033 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x000E, b=0x000E, cin=0 -> sum=0x001C, cout=0, ovf=0.
REQ-034 a=0x1234, b=0x4321, cin=1, out_ready low for 10 cycles -> sum=0x5556 held stable with out_valid=1 throughout; released one cycle after out_ready=1.
REQ-035 rst=1 at cycle 2 of RUN -> next cycle IDLE, out_valid=0, sum=0, in_ready=1; a following a=0x0000, b=0x0001, cin=1 -> sum=0x0002, cout=0.
REQ-036 WIDTH=CHUNK=8: a=0xFF, b=0xFF, cin=1 -> out_valid at cycle 2, sum=0xFF, cout=1, ovf=0.
REQ-037 Randomised back-to-back transactions with in_valid held high -> every result matches the reference sum, and no operand is accepted outside IDLE.
